// File: rtl/int_ctrl_if.sv
// System clock/reset bundle for the interrupt unit.
interface sys_if;
  logic clk;
  logic n_reset;
  modport master (output clk, output n_reset);
  modport slave  (input  clk, input  n_reset);
endinterface

// File: rtl/int_ctrl.sv
// Interrupt/vector unit ahead of the CPU sequencer: pin sync, pending latches, vector fetch.
// Optional INT_HIJACK_EN: an NMI arriving during an IRQ/BRK request takes over the vector.
module int_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = 16'hFFFA,
  parameter logic [15:0] VEC_RST     = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
  sys_if.slave        sys,
  input  logic        n_nmi,
  input  logic        n_irq,
  input  logic        p_i,
  input  logic        brk,
  input  logic        ins_boundary,
  input  logic        int_ack,
  output logic        int_req,
  output logic [1:0]  int_type,
  output logic        b_flag,
  output logic        vec_addr_oe,
  output logic [15:0] vec_addr,
  output logic        vec_done,
  output logic        p_set_i
);

  typedef enum logic [1:0] {IDLE, REQ, VECL, VECH} state_t;
  localparam logic [1:0] T_RST = 2'd0, T_NMI = 2'd1, T_IRQ = 2'd2, T_BRK = 2'd3;

  state_t state, state_d;
  logic [1:0] type_q, type_d;
  logic       b_q, b_d;
  logic [SYNC_STAGES-1:0] nmi_sync, irq_sync;
  logic n_nmi_s, n_nmi_s_d, n_irq_s;
  logic nmi_edge, irq_act, nmi_pend, rst_pend, nmi_clr, rst_clr;
  logic [15:0] base;

  assign n_nmi_s  = nmi_sync[SYNC_STAGES-1];
  assign n_irq_s  = irq_sync[SYNC_STAGES-1];
  assign nmi_edge = n_nmi_s_d & ~n_nmi_s;
  assign irq_act  = ~n_irq_s & ~p_i;
  assign nmi_clr  = (state == VECL) && (type_q == T_NMI);
  assign rst_clr  = (state == VECL) && (type_q == T_RST);

  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      nmi_sync  <= '1;
      irq_sync  <= '1;
      n_nmi_s_d <= 1'b1;
      nmi_pend  <= 1'b0;
      rst_pend  <= 1'b1;
    end else begin
      nmi_sync  <= {nmi_sync[SYNC_STAGES-2:0], n_nmi};
      irq_sync  <= {irq_sync[SYNC_STAGES-2:0], n_irq};
      n_nmi_s_d <= n_nmi_s;
      // a fresh edge in the clearing cycle must survive
      nmi_pend  <= (nmi_pend & ~nmi_clr) | nmi_edge;
      rst_pend  <= rst_pend & ~rst_clr;
    end
  end

  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      state  <= IDLE;
      type_q <= T_RST;
      b_q    <= 1'b0;
    end else begin
      state  <= state_d;
      type_q <= type_d;
      b_q    <= b_d;
    end
  end

  always_comb begin
    state_d = state;
    type_d  = type_q;
    b_d     = b_q;
    case (state)
      IDLE: begin
        if (ins_boundary && (rst_pend || nmi_pend || brk || irq_act)) begin
          state_d = REQ;
          if (rst_pend)      type_d = T_RST;
          else if (nmi_pend) type_d = T_NMI;
          else if (brk)      type_d = T_BRK;
          else               type_d = T_IRQ;
          b_d = ~rst_pend & ~nmi_pend & brk;
        end
      end
      REQ: begin
`ifdef INT_HIJACK_EN
        if ((type_q == T_IRQ || type_q == T_BRK) && (nmi_pend || nmi_edge))
          type_d = T_NMI;
`endif
        if (int_ack) state_d = VECL;
      end
      VECL:    state_d = VECH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (type_q)
      T_RST:   base = VEC_RST;
      T_NMI:   base = VEC_NMI;
      default: base = VEC_IRQ;
    endcase
  end

  assign int_req     = (state == REQ);
  assign int_type    = type_q;
  assign b_flag      = b_q;
  assign vec_addr_oe = (state == VECL) || (state == VECH);
  assign vec_addr    = (state == VECL) ? base :
                       (state == VECH) ? base + 16'd1 : 16'd0;
  assign vec_done    = (state == VECH);
  assign p_set_i     = (state == VECH);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, RST/IRQ/NMI/BRK services, priority, mid-service reset.
module tb_int_ctrl;
  sys_if sys ();
  logic n_nmi, n_irq, p_i, brk, ins_boundary, int_ack;
  logic int_req, b_flag, vec_addr_oe, vec_done, p_set_i;
  logic [1:0] int_type;
  logic [15:0] vec_addr;
  int n_assert = 0;
  int n_fail = 0;

  int_ctrl dut (
    .sys(sys), .n_nmi(n_nmi), .n_irq(n_irq), .p_i(p_i), .brk(brk),
    .ins_boundary(ins_boundary), .int_ack(int_ack), .int_req(int_req),
    .int_type(int_type), .b_flag(b_flag), .vec_addr_oe(vec_addr_oe),
    .vec_addr(vec_addr), .vec_done(vec_done), .p_set_i(p_set_i)
  );

  initial sys.clk = 1'b0;
  always #5 sys.clk = ~sys.clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge sys.clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},  {15'd0, int_req}, 16'd0);
    chk({tag, "_type"}, {14'd0, int_type}, 16'd0);
    chk({tag, "_b"},    {15'd0, b_flag}, 16'd0);
    chk({tag, "_oe"},   {15'd0, vec_addr_oe}, 16'd0);
    chk({tag, "_addr"}, vec_addr, 16'd0);
    chk({tag, "_done"}, {15'd0, vec_done}, 16'd0);
    chk({tag, "_seti"}, {15'd0, p_set_i}, 16'd0);
  endtask

  // Called at a negedge while the DUT is in REQ; runs ack and the two vector cycles.
  task automatic service(input string tag, input logic [1:0] t, input logic [15:0] va, input logic b);
    chk({tag, "_req"},  {15'd0, int_req}, 16'd1);
    chk({tag, "_type"}, {14'd0, int_type}, {14'd0, t});
    chk({tag, "_b"},    {15'd0, b_flag}, {15'd0, b});
    ins_boundary = 1'b0;
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    chk({tag, "_req_drop"}, {15'd0, int_req}, 16'd0);
    chk({tag, "_oe_lo"},    {15'd0, vec_addr_oe}, 16'd1);
    chk({tag, "_addr_lo"},  vec_addr, va);
    chk({tag, "_done_lo"},  {15'd0, vec_done}, 16'd0);
    tick;
    chk({tag, "_oe_hi"},    {15'd0, vec_addr_oe}, 16'd1);
    chk({tag, "_addr_hi"},  vec_addr, va + 16'd1);
    chk({tag, "_done_hi"},  {15'd0, vec_done}, 16'd1);
    chk({tag, "_seti_hi"},  {15'd0, p_set_i}, 16'd1);
    chk({tag, "_b_hi"},     {15'd0, b_flag}, {15'd0, b});
    tick;
    chk({tag, "_done_end"}, {15'd0, vec_done}, 16'd0);
    chk({tag, "_seti_end"}, {15'd0, p_set_i}, 16'd0);
    chk({tag, "_oe_end"},   {15'd0, vec_addr_oe}, 16'd0);
  endtask

  initial begin
    sys.n_reset = 1'b0;
    n_nmi = 1'b1; n_irq = 1'b1; p_i = 1'b1; brk = 1'b0;
    ins_boundary = 1'b0; int_ack = 1'b0;
    repeat (2) tick;
    chk_reset_outs("rst_state");

    // power-on reset service
    ins_boundary = 1'b1;
    sys.n_reset = 1'b1;
    tick;
    service("rst", 2'd0, 16'hFFFC, 1'b0);
    ins_boundary = 1'b1;
    repeat (3) tick;
    chk("rst_cleared", {15'd0, int_req}, 16'd0);

    // IRQ masked by I flag, then unmasked
    n_irq = 1'b0; p_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("irq_masked", {15'd0, int_req}, 16'd0);
    end
    p_i = 1'b0;
    tick;
    service("irq", 2'd2, 16'hFFFE, 1'b0);
    p_i = 1'b1; n_irq = 1'b1;
    repeat (4) tick;

    // NMI edge, held low: exactly one service
    n_nmi = 1'b0;
    repeat (4) tick;
    ins_boundary = 1'b1;
    tick;
    service("nmi", 2'd1, 16'hFFFA, 1'b0);
    ins_boundary = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      chk("nmi_no_retrig", {15'd0, int_req}, 16'd0);
    end
    ins_boundary = 1'b0; n_nmi = 1'b1;
    repeat (4) tick;

    // NMI and IRQ together: NMI first, IRQ at the next boundary
    n_nmi = 1'b0; n_irq = 1'b0; p_i = 1'b0;
    repeat (4) tick;
    ins_boundary = 1'b1;
    tick;
    service("prio_nmi", 2'd1, 16'hFFFA, 1'b0);
    ins_boundary = 1'b1;
    tick;
    service("prio_irq", 2'd2, 16'hFFFE, 1'b0);
    p_i = 1'b1; n_irq = 1'b1; n_nmi = 1'b1;
    repeat (4) tick;

    // BRK, with an NMI edge arriving while in REQ
    brk = 1'b1; ins_boundary = 1'b1;
    tick;
    brk = 1'b0; ins_boundary = 1'b0;
    n_nmi = 1'b0;
    repeat (4) tick;
    chk("brk_hold", {15'd0, int_req}, 16'd1);
`ifdef INT_HIJACK_EN
    service("brk_hijack", 2'd1, 16'hFFFA, 1'b1);
    ins_boundary = 1'b1;
    repeat (3) tick;
    chk("hijack_nmi_consumed", {15'd0, int_req}, 16'd0);
`else
    service("brk", 2'd3, 16'hFFFE, 1'b1);
    ins_boundary = 1'b1;
    tick;
    service("nmi_after_brk", 2'd1, 16'hFFFA, 1'b0);
`endif
    ins_boundary = 1'b0; n_nmi = 1'b1;
    repeat (4) tick;

    // reset asserted in VECH of an NMI service
    n_nmi = 1'b0;
    repeat (4) tick;
    ins_boundary = 1'b1;
    tick;
    ins_boundary = 1'b0;
    chk("mid_type", {14'd0, int_type}, 16'd1);
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    tick;
    chk("mid_vech", {15'd0, vec_done}, 16'd1);
    sys.n_reset = 1'b0;
    n_nmi = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    tick;
    ins_boundary = 1'b1;
    sys.n_reset = 1'b1;
    tick;
    service("rst2", 2'd0, 16'hFFFC, 1'b0);
    ins_boundary = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("no_nmi_after_rst", {15'd0, int_req}, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt and vector unit that sits directly upstream of the CPU sequencer. It synchronises the NMI and IRQ pins and latches pending reset, NMI, BRK and IRQ requests. At instruction boundaries it raises a request to the sequencer and reports its type. Once the sequencer acknowledges, it drives the two-byte vector fetch address, then signals completion and an I-flag set.

Parameters:
SYNC_STAGES, 2, number of flops in each pin synchroniser (legal values are 2 or more)
VEC_NMI, 16'hFFFA, low-byte address of the NMI vector
VEC_RST, 16'hFFFC, low-byte address of the reset vector
VEC_IRQ, 16'hFFFE, low-byte address of the IRQ/BRK vector

Ports:
sys.clk  input  1  system clock, carried in sys_if
sys.n_reset  input  1  asynchronous active-low reset, carried in sys_if
n_nmi  input  1  asynchronous NMI pin, active low
n_irq  input  1  asynchronous IRQ pin, active low
p_i  input  1  status register I flag
brk  input  1  BRK opcode decoded; level, sampled at a boundary
ins_boundary  input  1  sequencer is in its Fetch state
int_ack  input  1  sequencer has finished its pushes and is ready for the vector; one-cycle pulse
int_req  output  1  request to the sequencer to run the interrupt sequence instead of fetching
int_type  output  2  0=RST, 1=NMI, 2=IRQ, 3=BRK; valid while int_req or vec_addr_oe is high
b_flag  output  1  value of the B bit to push; 1 only for BRK
vec_addr_oe  output  1  this block drives the address bus
vec_addr  output  16  vector address
vec_done  output  1  one-cycle pulse: vector high byte has been read and PC load is due
p_set_i  output  1  one-cycle pulse that sets the I flag

Behaviour:
- Reset is asynchronous. Reset values:
  - outputs: int_req=0, int_type=0, b_flag=0, vec_addr_oe=0, vec_addr=0, vec_done=0, p_set_i=0
  - state=IDLE, synchroniser flops all 1, rst_pend=1, nmi_pend=0
- Synchronisers: SYNC_STAGES flops per pin. The unit reacts to pin activity SYNC_STAGES cycles after the pin changes.
- NMI: a 1->0 transition of the synchronised n_nmi sets nmi_pend. A low level held on the pin does not re-trigger.
- irq_act = ~n_irq_s & ~p_i. It is combinational and never latched.
- Priority at a boundary: RST > NMI > BRK > IRQ.
- State machine:
  - IDLE:
    - If ins_boundary and any source is active, latch int_type, set b_flag=(type==BRK), assert int_req, go to REQ.
    - If ins_boundary is high but no source is active, stay idle.
  - REQ:
    - Hold int_req and int_type stable until int_ack.
    - On int_ack, deassert int_req and go to VECL.
    - int_ack outside REQ is ignored.
  - VECL:
    - vec_addr_oe=1, vec_addr = vector base for int_type.
    - Clear nmi_pend if type is NMI; clear rst_pend if type is RST.
    - Go to VECH.
  - VECH:
    - vec_addr_oe=1, vec_addr = base+1.
    - Pulse vec_done and p_set_i.
    - Go to IDLE.
- Vector mapping: RST uses VEC_RST; NMI uses VEC_NMI; IRQ and BRK use VEC_IRQ.
- Latency: from a boundary with a source active to int_req high is 1 cycle. From int_ack to vec_done is 2 cycles.
- Simultaneous events:
  - If an NMI edge arrives in the same cycle as the VECL clear, set wins and nmi_pend stays 1.
  - An NMI edge that arrives during an IRQ or BRK service stays pending. It is taken at the next boundary.
- IRQ dropped while in REQ: the request is not withdrawn and the service completes as IRQ.
- Reset asserted mid-operation: the unit returns to IDLE, rst_pend is set to 1, and any pending NMI is lost.

Optional Feature:
INT_HIJACK_EN
- Defined: while in REQ with int_type IRQ or BRK, an NMI edge (or an already-set nmi_pend) switches int_type to NMI before int_ack. b_flag is preserved when the original type was BRK. The vector then comes from VEC_NMI and nmi_pend clears in VECL.
- Undefined: int_type is frozen from the moment of entering REQ.

Test Plan:
- Release reset, ins_boundary=1 -> int_req=1 with int_type=0 on the first cycle after release; int_ack -> vec_addr FFFC then FFFD with vec_addr_oe=1, vec_done pulses in the FFFD cycle, rst_pend=0.
- n_irq=0, p_i=1 for 20 cycles with boundaries -> int_req stays 0; set p_i=0 -> int_req=1, int_type=2, vector reads at FFFE/FFFF, p_set_i pulses once.
- n_nmi driven high->low and held low for 50 cycles -> exactly one service with int_type=1 at FFFA/FFFB; no second int_req afterwards.
- NMI edge and IRQ active at the same boundary -> NMI is served first; IRQ is served at the next boundary if p_i=0.
- brk=1 at a boundary -> int_type=3, b_flag=1, vectors FFFE/FFFF; with INT_HIJACK_EN, an NMI edge in REQ -> vectors FFFA/FFFB with b_flag=1.
- Assert n_reset while in VECH with type NMI -> all outputs take their reset values immediately; after release the next service is RST and no NMI service occurs.
